debounce_multi: RTL and testbench

- Parametrised N-channel debouncer for the board push-buttons and switches (fire, left, right, start).
- Per channel it provides:
  - a two-flop synchroniser;
  - a debounce counter;
  - a debounced level;
  - one-cycle rise and fall pulses;
  - an optional auto-repeat "press" pulse train while the input is held.
- Sits between the raw board pins and the game control logic; all outputs are synchronous to i_Clk.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_channel.sv | 165 ++++++++++++++++
 rtl/debounce_multi.sv | 54 +++++
 tb/tb_debounce_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types, timing defaults and helpers for the multi-channel debouncer.
package debounce_pkg;

  // Auto-repeat state per channel
  typedef enum logic [1:0] {
    R_OFF    = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rpt_state_e;

  // Default timings for a 25 MHz board clock
  localparam int DEB_10MS  = 250000;
  localparam int RPT_500MS = 12500000;
  localparam int RPT_100MS = 2500000;

  // Bits needed to hold the larger of two counts (inclusive)
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, stability counter,
// registered edge pulses and an auto-repeat press generator.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEB_10MS,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   REPEAT_EN       = 1,
  parameter int   REPEAT_DELAY    = RPT_500MS,
  parameter int   REPEAT_RATE     = RPT_100MS,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int   RPT_W           = clog2_max(REPEAT_DELAY, REPEAT_RATE)
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             st_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rise_r;
  logic             fall_r;
  logic             press_r;
  rpt_state_e       rstate_r;
  logic [RPT_W-1:0] rcnt_r;

  logic             st_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;
  logic             rise_s;
  logic             fall_s;
  rpt_state_e       rstate_nxt_s;
  logic [RPT_W-1:0] rcnt_nxt_s;
  logic             rpt_pulse_s;

  // Bring the raw pin into the clock domain
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_r <= RESET_LEVEL;
      sync2_r <= RESET_LEVEL;
    end else begin
      sync1_r <= i_Switch;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive cycles of disagreement; any agreement discards progress
  always_comb begin
    st_nxt_s  = st_r;
    cnt_nxt_s = '0;
    accept_s  = 1'b0;
    if (sync2_r == st_r) begin
      cnt_nxt_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      accept_s  = 1'b1;
      st_nxt_s  = sync2_r;
      cnt_nxt_s = '0;
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  assign rise_s = accept_s & sync2_r;
  assign fall_s = accept_s & ~sync2_r;

  // Debounced level and counter state
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      st_r  <= RESET_LEVEL;
      cnt_r <= '0;
    end else begin
      st_r  <= st_nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

  // Repeat FSM next state; an accepted fall beats a coincident repeat pulse
  always_comb begin
    rstate_nxt_s = rstate_r;
    rcnt_nxt_s   = rcnt_r;
    rpt_pulse_s  = 1'b0;
    if (REPEAT_EN != 0) begin
      case (rstate_r)
        R_OFF: begin
          rcnt_nxt_s = '0;
          if (rise_s) begin
            rstate_nxt_s = R_DELAY;
          end else begin
            rstate_nxt_s = R_OFF;
          end
        end
        R_DELAY: begin
          if (fall_s) begin
            rstate_nxt_s = R_OFF;
            rcnt_nxt_s   = '0;
          end else if (rcnt_r == DLY_LAST) begin
            rpt_pulse_s  = 1'b1;
            rstate_nxt_s = R_REPEAT;
            rcnt_nxt_s   = '0;
          end else begin
            rcnt_nxt_s = rcnt_r + RPT_W'(1);
          end
        end
        R_REPEAT: begin
          if (fall_s) begin
            rstate_nxt_s = R_OFF;
            rcnt_nxt_s   = '0;
          end else if (rcnt_r == RATE_LAST) begin
            rpt_pulse_s = 1'b1;
            rcnt_nxt_s  = '0;
          end else begin
            rcnt_nxt_s = rcnt_r + RPT_W'(1);
          end
        end
        default: begin
          rstate_nxt_s = R_OFF;
          rcnt_nxt_s   = '0;
        end
      endcase
    end else begin
      rstate_nxt_s = R_OFF;
      rcnt_nxt_s   = '0;
    end
  end

  // Repeat FSM state and delay/rate counter
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rstate_r <= R_OFF;
      rcnt_r   <= '0;
    end else begin
      rstate_r <= rstate_nxt_s;
      rcnt_r   <= rcnt_nxt_s;
    end
  end

  // Registered pulses, aligned with the o_Switch change
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      press_r <= rise_s | rpt_pulse_s;
    end
  end

  assign o_Switch = st_r;
  assign o_Rise   = rise_r;
  assign o_Fall   = fall_r;
  assign o_Press  = press_r;

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels for the board buttons and switches.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int   NUM_CH          = 4,
  parameter int   DEBOUNCE_CYCLES = DEB_10MS,
  parameter logic RESET_LEVEL     = 1'b0,
  parameter int   REPEAT_EN       = 1,
  parameter int   REPEAT_DELAY    = RPT_500MS,
  parameter int   REPEAT_RATE     = RPT_100MS,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int   RPT_W           = clog2_max(REPEAT_DELAY, REPEAT_RATE)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Press
);

  // Reject timing parameters the counters cannot represent
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("debounce_multi: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_dly
    $error("debounce_multi: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_RATE < 1) begin : g_bad_rate
    $error("debounce_multi: REPEAT_RATE must be >= 1");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .CNT_W           (CNT_W),
      .RPT_W           (RPT_W)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Rst_L  (i_Rst_L),
      .i_Switch (i_Switch[ch]),
      .o_Switch (o_Switch[ch]),
      .o_Rise   (o_Rise[ch]),
      .o_Fall   (o_Fall[ch]),
      .o_Press  (o_Press[ch])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: 2 channels, 4-cycle debounce,
// 10-cycle repeat delay, 3-cycle repeat rate. Edge k counts from the first
// clock edge that samples the new input value.
module tb_debounce_multi;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b1;
  logic [1:0] i_Switch = 2'b00;
  logic [1:0] o_Switch;
  logic [1:0] o_Rise;
  logic [1:0] o_Fall;
  logic [1:0] o_Press;

  int checks = 0;
  int failures = 0;

  debounce_multi #(
    .NUM_CH          (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Switch (i_Switch),
    .o_Switch (o_Switch),
    .o_Rise   (o_Rise),
    .o_Fall   (o_Fall),
    .o_Press  (o_Press)
  );

  always #5 i_Clk = ~i_Clk;

  // Advance past one rising edge and sample away from it
  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Expected ch0 press pattern for a press first sampled at edge 0
  function automatic logic press_pat(input int k);
    return (k == 5) || (k >= 15 && ((k - 15) % 3) == 0);
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    i_Switch = 2'b00;
    #2;
    i_Rst_L = 1'b0;
    #3;
    got = {o_Switch, o_Rise, o_Fall, o_Press};
    checks++;
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", got, 8'h00);
    end
    tick();
    i_Rst_L = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== 8'h00) begin
        failures++;
        $display("FAIL idle_low k=%0d got=%b exp=%b", k, got, 8'h00);
      end
    end
  endtask

  task automatic test_rise_repeat_release();
    logic [7:0] got;
    logic [7:0] exp;
    int g;
    i_Switch = 2'b01;
    for (int k = 0; k <= 22; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 5), 1'b0, 1'(k == 5), 1'b0, 1'b0, 1'b0, press_pat(k)};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold_repeat k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    i_Switch = 2'b00;
    for (int j = 0; j <= 14; j++) begin
      tick();
      g = 23 + j;
      exp = {1'b0, 1'(g < 28), 1'b0, 1'b0, 1'b0, 1'(g == 28), 1'b0, 1'(g < 28 && press_pat(g))};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL release j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] got;
    logic [7:0] exp;
    int rises;
    rises = 0;
    for (int k = 0; k <= 12; k++) begin
      i_Switch = (k == 3) ? 2'b00 : 2'b01;
      tick();
      if (o_Rise[0] === 1'b1) rises++;
      exp = {1'b0, 1'(k >= 9), 1'b0, 1'(k == 9), 1'b0, 1'b0, 1'b0, 1'(k == 9)};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bounce k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    checks++;
    if (rises !== 1) begin
      failures++;
      $display("FAIL bounce_rise_count got=%0d exp=%0d", rises, 1);
    end
    i_Switch = 2'b00;
    repeat (20) tick();
  endtask

  task automatic test_simultaneous();
    logic [7:0] got;
    logic [7:0] exp;
    logic [1:0] sw;
    logic [1:0] ev;
    i_Switch = 2'b11;
    for (int k = 0; k <= 7; k++) begin
      tick();
      sw  = (k >= 5) ? 2'b11 : 2'b00;
      ev  = (k == 5) ? 2'b11 : 2'b00;
      exp = {sw, ev, 2'b00, ev};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL simul_rise k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    i_Switch = 2'b00;
    for (int j = 0; j <= 7; j++) begin
      tick();
      sw  = (j < 5) ? 2'b11 : 2'b00;
      ev  = (j == 5) ? 2'b11 : 2'b00;
      exp = {sw, 2'b00, ev, 2'b00};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL simul_fall j=%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_independence();
    logic [7:0] got;
    logic [7:0] exp;
    for (int k = 0; k <= 28; k++) begin
      i_Switch = {1'(k >= 8 && k < 16), 1'b1};
      tick();
      exp = {1'(k >= 13 && k < 21), 1'(k >= 5),
             1'(k == 13), 1'(k == 5),
             1'(k == 21), 1'b0,
             1'(k == 13), press_pat(k)};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL independence k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    i_Switch = 2'b00;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic [7:0] exp;
    i_Switch = 2'b01;
    repeat (4) tick();
    i_Rst_L = 1'b0;
    #1;
    got = {o_Switch, o_Rise, o_Fall, o_Press};
    checks++;
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL reset_midcount got=%b exp=%b", got, 8'h00);
    end
    tick();
    tick();
    i_Rst_L = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 5), 1'b0, 1'(k == 5), 1'b0, 1'b0, 1'b0, press_pat(k)};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL after_reset k=%0d got=%b exp=%b", k, got, exp);
      end
    end
    i_Rst_L = 1'b0;
    #1;
    got = {o_Switch, o_Rise, o_Fall, o_Press};
    checks++;
    if (got !== 8'h00) begin
      failures++;
      $display("FAIL reset_midrepeat got=%b exp=%b", got, 8'h00);
    end
    tick();
    i_Rst_L = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      exp = {1'b0, 1'(k >= 5), 1'b0, 1'(k == 5), 1'b0, 1'b0, 1'b0, press_pat(k)};
      got = {o_Switch, o_Rise, o_Fall, o_Press};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL redebounce k=%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_repeat_release();
    test_bounce();
    test_simultaneous();
    test_independence();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
